// File: rtl/gyro_spi.sv
// SPI mode-3 master for the gyro register sequencer: one 16-bit command/data
// transfer per level request, finished with a four-phase done handshake.
module gyro_spi (
  input  logic       gyroclk,
  input  logic       resetn,
  input  logic       gyrowdav,
  output logic       wdavgyro,
  input  logic [5:0] gyroaddr,
  input  logic [7:0] gyrowdata,
  input  logic       gyrordav,
  output logic       rdavgyro,
  output logic [7:0] gyrodata,
  output logic       gyrosclk,
  output logic       gyrosdi,
  input  logic       gyrosdo,
  output logic       gyross
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, ACK} state_t;

  state_t      state, state_n;
  logic        cnt, cnt_n;
  logic [1:0]  phase, phase_n;
  logic [3:0]  bit_idx, bit_n;
  logic [1:0]  guard, guard_n;
  logic        is_read, is_read_n;
  logic [15:0] tx, tx_n;
  logic [7:0]  rx, rx_n;
  logic        ss_n, sclk_n, sdi_n, wdav_n, rdav_n;
  logic [7:0]  data_n;

  always_ff @(posedge gyroclk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= 1'b0;
      phase    <= '0;
      bit_idx  <= '0;
      guard    <= 2'd2;
      is_read  <= 1'b0;
      tx       <= '0;
      rx       <= '0;
      gyross   <= 1'b1;
      gyrosclk <= 1'b1;
      gyrosdi  <= 1'b0;
      wdavgyro <= 1'b0;
      rdavgyro <= 1'b0;
      gyrodata <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      phase    <= phase_n;
      bit_idx  <= bit_n;
      guard    <= guard_n;
      is_read  <= is_read_n;
      tx       <= tx_n;
      rx       <= rx_n;
      gyross   <= ss_n;
      gyrosclk <= sclk_n;
      gyrosdi  <= sdi_n;
      wdavgyro <= wdav_n;
      rdavgyro <= rdav_n;
      gyrodata <= data_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    phase_n   = phase;
    bit_n     = bit_idx;
    guard_n   = guard;
    is_read_n = is_read;
    tx_n      = tx;
    rx_n      = rx;
    ss_n      = gyross;
    sclk_n    = gyrosclk;
    sdi_n     = gyrosdi;
    wdav_n    = wdavgyro;
    rdav_n    = rdavgyro;
    data_n    = gyrodata;

    // guard = chip-select-high cycles elapsed, including the current one
    if (gyross && guard != 2'd2) guard_n = guard + 2'd1;

    case (state)
      IDLE: begin
        if (guard == 2'd2 && (gyrowdav || gyrordav)) begin
          is_read_n = !gyrowdav;
          tx_n      = {!gyrowdav, 1'b0, gyroaddr, gyrowdav ? gyrowdata : 8'h00};
          ss_n      = 1'b0;
          sclk_n    = 1'b1;
          sdi_n     = !gyrowdav;
          cnt_n     = 1'b0;
          state_n   = SETUP;
        end
      end
      SETUP: begin
        if (cnt) begin
          state_n = SHIFT;
          phase_n = '0;
          bit_n   = '0;
          sclk_n  = 1'b0;
          sdi_n   = tx[15];
        end else begin
          cnt_n = 1'b1;
        end
      end
      SHIFT: begin
        case (phase)
          2'd1: begin
            phase_n = 2'd2;
            sclk_n  = 1'b1;
          end
          2'd3: begin
            rx_n    = {rx[6:0], gyrosdo};
            phase_n = '0;
            if (bit_idx == 4'd15) begin
              state_n = HOLD;
              cnt_n   = 1'b0;
              bit_n   = '0;
            end else begin
              // tx shifts left so the next bit to drive always sits at tx[14]
              bit_n  = bit_idx + 4'd1;
              tx_n   = {tx[14:0], 1'b0};
              sclk_n = 1'b0;
              sdi_n  = tx[14];
            end
          end
          default: phase_n = phase + 2'd1;
        endcase
      end
      HOLD: begin
        if (cnt) begin
          state_n = ACK;
          ss_n    = 1'b1;
          guard_n = 2'd1;
          if (is_read) begin
            rdav_n = 1'b1;
            data_n = rx;
          end else begin
            wdav_n = 1'b1;
          end
        end else begin
          cnt_n = 1'b1;
        end
      end
      ACK: begin
        if (is_read ? !gyrordav : !gyrowdav) begin
          rdav_n  = 1'b0;
          wdav_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
